// File: rtl/idli_sqi_ctrl_m.sv
`default_nettype none
// ============================================================================
// Module   : idli_sqi_ctrl_m
// Purpose  : SQI memory controller. It drives the chip select and SIO pins of
//            an external SQI SRAM. A burst sends a command byte, a 24-bit byte
//            address and, for reads only, a two-nibble turnaround. After that
//            it streams one 16-bit word per four-cycle GCK period until it is
//            told to stop.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_sq_gck        in   1   clock, one nibble per cycle
//   i_sq_rst        in   1   synchronous reset, active-high
//   i_sq_ctr        in   2   free-running period slice counter, 0..3
//   i_sq_req        in   1   burst request (level, sampled in IDLE only)
//   i_sq_wr         in   1   1 = write burst, 0 = read burst
//   i_sq_addr       in  16   word address of the burst
//   i_sq_stop       in   1   end the burst after the current data period
//   i_sq_wdata      in  16   write word, sampled at ctr==3 before each period
//   o_sq_rdata      out 16   read word, meaningful only with o_sq_rdata_vld
//   o_sq_rdata_vld  out  1   read word complete (ctr==3 of a read period)
//   o_sq_busy       out  1   controller not idle
//   o_sq_cs_n       out  1   SQI chip select, active-low
//   o_sq_sio_oe     out  1   1 = controller drives SIO
//   o_sq_sio        out  4   SIO output nibble
//   i_sq_sio        in   4   SIO input nibble
// ============================================================================
module idli_sqi_ctrl_m #(
  parameter logic [7:0] CMD_READ  = 8'h03,
  parameter logic [7:0] CMD_WRITE = 8'h02
) (
  input  logic        i_sq_gck,
  input  logic        i_sq_rst,
  input  logic [1:0]  i_sq_ctr,
  input  logic        i_sq_req,
  input  logic        i_sq_wr,
  input  logic [15:0] i_sq_addr,
  input  logic        i_sq_stop,
  input  logic [15:0] i_sq_wdata,
  output logic [15:0] o_sq_rdata,
  output logic        o_sq_rdata_vld,
  output logic        o_sq_busy,
  output logic        o_sq_cs_n,
  output logic        o_sq_sio_oe,
  output logic [3:0]  o_sq_sio,
  input  logic [3:0]  i_sq_sio
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMD   = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_DUMMY = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;

  // Last nibble index of each overhead phase.
  localparam logic [3:0] CMD_LAST   = 4'd1;
  localparam logic [3:0] ADDR_LAST  = 4'd5;
  localparam logic [3:0] DUMMY_LAST = 4'd1;

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic [3:0]  nib;
  logic [3:0]  nib_next;

  logic        wr_q;       // burst direction latched at acceptance
  logic [15:0] addr_q;     // word address latched at acceptance
  logic [15:0] wdata_q;    // word being serialised in the current period
  logic [11:0] rd_sh;      // read slices 0..2 of the current period

  logic        accept;
  logic        stop_now;
  logic        period_end;
  logic        wdata_load;
  logic [23:0] byte_addr;
  logic [7:0]  cmd_byte;

  assign period_end = (i_sq_ctr == 2'd3);

  // The overhead lengths differ between directions: 8 nibbles for a write and
  // 10 for a read. Accepting at different slices lets the first data nibble
  // land on ctr==0 in both cases.
  assign accept = (state == ST_IDLE) && i_sq_req &&
                  ((i_sq_wr && (i_sq_ctr == 2'd3)) ||
                   (!i_sq_wr && (i_sq_ctr == 2'd1)));

  assign stop_now  = (state == ST_DATA) && period_end && i_sq_stop;
  assign byte_addr = {7'b0, addr_q, 1'b0};
  assign cmd_byte  = wr_q ? CMD_WRITE : CMD_READ;

  // A write word is loaded on the slice just before each data period. That
  // slice is the last address nibble for the first period and ctr==3 of the
  // previous data period after that.
  assign wdata_load = wr_q && period_end &&
                      (((state == ST_ADDR) && (nib == ADDR_LAST)) ||
                       (state == ST_DATA));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_sq_gck) begin
    if (i_sq_rst) begin
      state <= ST_IDLE;
      nib   <= 4'd0;
    end else begin
      state <= state_next;
      nib   <= nib_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    nib_next   = nib;
    case (state)
      ST_IDLE: begin
        nib_next = 4'd0;
        if (accept) begin
          state_next = ST_CMD;
        end
      end
      ST_CMD: begin
        if (nib == CMD_LAST) begin
          state_next = ST_ADDR;
          nib_next   = 4'd0;
        end else begin
          nib_next = nib + 4'd1;
        end
      end
      ST_ADDR: begin
        if (nib == ADDR_LAST) begin
          state_next = wr_q ? ST_DATA : ST_DUMMY;
          nib_next   = 4'd0;
        end else begin
          nib_next = nib + 4'd1;
        end
      end
      ST_DUMMY: begin
        if (nib == DUMMY_LAST) begin
          state_next = ST_DATA;
          nib_next   = 4'd0;
        end else begin
          nib_next = nib + 4'd1;
        end
      end
      ST_DATA: begin
        // The data phase is paced by i_sq_ctr, not by the nibble counter.
        nib_next = 4'd0;
        if (stop_now) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        nib_next   = 4'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers: request capture, write word, read slices
  // --------------------------------------------------------------------------
  always_ff @(posedge i_sq_gck) begin
    if (i_sq_rst) begin
      wr_q    <= 1'b0;
      addr_q  <= 16'd0;
      wdata_q <= 16'd0;
      rd_sh   <= 12'd0;
    end else begin
      if (accept) begin
        wr_q   <= i_sq_wr;
        addr_q <= i_sq_addr;
      end
      if (wdata_load) begin
        wdata_q <= i_sq_wdata;
      end
      if ((state == ST_DATA) && !wr_q) begin
        case (i_sq_ctr)
          2'd0:    rd_sh[11:8] <= i_sq_sio;
          2'd1:    rd_sh[7:4]  <= i_sq_sio;
          2'd2:    rd_sh[3:0]  <= i_sq_sio;
          default: rd_sh       <= rd_sh;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    o_sq_cs_n   = 1'b1;
    o_sq_sio_oe = 1'b0;
    o_sq_sio    = 4'd0;
    case (state)
      ST_CMD: begin
        o_sq_cs_n   = 1'b0;
        o_sq_sio_oe = 1'b1;
        o_sq_sio    = (nib == 4'd0) ? cmd_byte[7:4] : cmd_byte[3:0];
      end
      ST_ADDR: begin
        o_sq_cs_n   = 1'b0;
        o_sq_sio_oe = 1'b1;
        case (nib)
          4'd0:    o_sq_sio = byte_addr[23:20];
          4'd1:    o_sq_sio = byte_addr[19:16];
          4'd2:    o_sq_sio = byte_addr[15:12];
          4'd3:    o_sq_sio = byte_addr[11:8];
          4'd4:    o_sq_sio = byte_addr[7:4];
          4'd5:    o_sq_sio = byte_addr[3:0];
          default: o_sq_sio = 4'd0;
        endcase
      end
      ST_DUMMY: begin
        o_sq_cs_n = 1'b0;
      end
      ST_DATA: begin
        o_sq_cs_n   = 1'b0;
        o_sq_sio_oe = wr_q;
        if (wr_q) begin
          case (i_sq_ctr)
            2'd0:    o_sq_sio = wdata_q[15:12];
            2'd1:    o_sq_sio = wdata_q[11:8];
            2'd2:    o_sq_sio = wdata_q[7:4];
            default: o_sq_sio = wdata_q[3:0];
          endcase
        end
      end
      default: begin
        o_sq_cs_n   = 1'b1;
        o_sq_sio_oe = 1'b0;
        o_sq_sio    = 4'd0;
      end
    endcase
  end

  assign o_sq_busy      = (state != ST_IDLE);
  // The final slice is taken straight from the pins, so the word is complete
  // on ctr==3 without waiting one more cycle.
  assign o_sq_rdata     = {rd_sh, i_sq_sio};
  assign o_sq_rdata_vld = (state == ST_DATA) && !wr_q && period_end;

endmodule
`default_nettype wire

// File: tb/tb_idli_sqi_ctrl_m.sv
`default_nettype none
// ============================================================================
// Module   : tb_idli_sqi_ctrl_m
// Purpose  : Directed self-checking bench for idli_sqi_ctrl_m. Expected pin
//            values and read words go into scoreboard queues when a burst is
//            launched. They are popped and compared cycle by cycle while the
//            burst runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_idli_sqi_ctrl_m;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  logic        clk;
  logic        rst;
  logic [1:0]  ctr;
  logic        req;
  logic        wr;
  logic [15:0] addr;
  logic        stop;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        rdata_vld;
  logic        busy;
  logic        cs_n;
  logic        sio_oe;
  logic [3:0]  sio_out;
  logic [3:0]  sio_in;

  idli_sqi_ctrl_m #(
    .CMD_READ  (CMD_READ),
    .CMD_WRITE (CMD_WRITE)
  ) dut (
    .i_sq_gck       (clk),
    .i_sq_rst       (rst),
    .i_sq_ctr       (ctr),
    .i_sq_req       (req),
    .i_sq_wr        (wr),
    .i_sq_addr      (addr),
    .i_sq_stop      (stop),
    .i_sq_wdata     (wdata),
    .o_sq_rdata     (rdata),
    .o_sq_rdata_vld (rdata_vld),
    .o_sq_busy      (busy),
    .o_sq_cs_n      (cs_n),
    .o_sq_sio_oe    (sio_oe),
    .o_sq_sio       (sio_out),
    .i_sq_sio       (sio_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       oe;
    logic [3:0] sio;
    logic       vld;
  } exp_t;

  exp_t        pin_q[$];
  logic [15:0] rd_q[$];
  logic [15:0] mem_w [0:2];

  int checks = 0;
  int errors = 0;
  int nvld   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle. The slice counter moves with the clock.
  task automatic adv();
    @(posedge clk);
    #1;
    ctr = ctr + 2'd1;
  endtask

  task automatic wait_ctr(input logic [1:0] target);
    for (int i = 0; i < 8 && ctr != target; i++) adv();
  endtask

  function automatic logic [3:0] nib_of24(input logic [23:0] v, input int j);
    logic [23:0] t;
    t = v >> (4 * (5 - j));
    return t[3:0];
  endfunction

  function automatic logic [3:0] nib_of16(input logic [15:0] v, input int k);
    logic [15:0] t;
    t = v >> (4 * (3 - k));
    return t[3:0];
  endfunction

  task automatic push_pin(input logic oe, input logic [3:0] s, input logic v);
    exp_t e;
    e.oe  = oe;
    e.sio = s;
    e.vld = v;
    pin_q.push_back(e);
  endtask

  task automatic push_header(input logic [7:0] cmd, input logic [15:0] a);
    logic [23:0] ba;
    ba = {7'b0, a, 1'b0};
    push_pin(1'b1, cmd[7:4], 1'b0);
    push_pin(1'b1, cmd[3:0], 1'b0);
    for (int j = 0; j < 6; j++) push_pin(1'b1, nib_of24(ba, j), 1'b0);
  endtask

  // Compare one in-burst cycle against the head of the scoreboard.
  task automatic check_cycle(input string tag);
    exp_t e;
    logic [15:0] w;
    #1;
    if (pin_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb_empty observed=%0d expected=1", tag, 0);
    end else begin
      e = pin_q.pop_front();
      chk({tag, "_cs_n"}, cs_n, 1'b0);
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_oe"}, sio_oe, e.oe);
      if (e.oe) chk({tag, "_sio"}, sio_out, e.sio);
      chk({tag, "_vld"}, rdata_vld, e.vld);
      if (rdata_vld) nvld++;
      if (e.vld && rd_q.size() != 0) begin
        w = rd_q.pop_front();
        chk({tag, "_rdata"}, rdata, w);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    #1;
    chk({tag, "_idle_cs_n"}, cs_n, 1'b1);
    chk({tag, "_idle_oe"}, sio_oe, 1'b0);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_idle_vld"}, rdata_vld, 1'b0);
  endtask

  // Call in a cycle with ctr==3. Runs one period and stops.
  task automatic write_burst(input logic [15:0] a, input logic [15:0] wd, input string tag);
    req = 1'b1; wr = 1'b1; addr = a; wdata = wd;
    push_header(CMD_WRITE, a);
    for (int k = 0; k < 4; k++) push_pin(1'b1, nib_of16(wd, k), 1'b0);
    for (int i = 0; i < 12; i++) begin
      adv();
      req  = 1'b0;
      stop = (i == 11);
      if (i == 0) begin addr = 16'hFFFF; wr = 1'b0; end
      if (i == 8) wdata = 16'h0000;
      check_cycle(tag);
    end
    adv();
    stop = 1'b0;
    check_idle(tag);
  endtask

  // Call in a cycle with ctr==1 and the read request presented.
  task automatic read_burst(input logic [15:0] a, input int nper, input logic inject, input string tag);
    int p;
    int k;
    req = 1'b1; wr = 1'b0; addr = a;
    push_header(CMD_READ, a);
    push_pin(1'b0, 4'd0, 1'b0);
    push_pin(1'b0, 4'd0, 1'b0);
    for (int q = 0; q < nper; q++) begin
      for (int kk = 0; kk < 4; kk++) push_pin(1'b0, 4'd0, kk == 3);
      rd_q.push_back(mem_w[q]);
    end
    nvld = 0;
    for (int i = 0; i < 10 + 4 * nper; i++) begin
      adv();
      req  = 1'b0;
      stop = 1'b0;
      if (i == 0) begin addr = 16'hFFFF; wr = 1'b1; end
      if (i >= 10) begin
        p = (i - 10) / 4;
        k = (i - 10) % 4;
        sio_in = nib_of16(mem_w[p], k);
        stop   = (k == 3) && (p == nper - 1);
        if (inject && k == 1) stop = 1'b1;
        if (inject && stop && k == 3) begin req = 1'b1; wr = 1'b1; end
      end else begin
        sio_in = 4'($urandom_range(0, 15));
        if (inject && i == 0) stop = 1'b1;
      end
      check_cycle(tag);
    end
    adv();
    stop = 1'b0; req = 1'b0; sio_in = 4'd0;
    check_idle(tag);
    chk({tag, "_vld_count"}, nvld, nper);
  endtask

  initial begin
    rst = 1'b1; ctr = 2'd0; req = 1'b0; wr = 1'b0; addr = 16'd0;
    stop = 1'b0; wdata = 16'd0; sio_in = 4'd0;
    adv(); adv(); adv();
    rst = 1'b0;
    #1;
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_oe", sio_oe, 1'b0);
    chk("rst_sio", sio_out, 4'd0);
    chk("rst_vld", rdata_vld, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdata", rdata, 16'h0000);

    // 1: single write period.
    wait_ctr(2'd3);
    write_burst(16'h1234, 16'hABCD, "wr1");

    // 2: single read period, memory returns 1,2,3,4.
    mem_w[0] = 16'h1234;
    wait_ctr(2'd1);
    read_burst(16'h0001, 1, 1'b0, "rd1");

    // 3 and 6: three-period read with ignored stops and a request at stop.
    mem_w[0] = 16'h5A5A; mem_w[1] = 16'hC3F0; mem_w[2] = 16'h0F1E;
    wait_ctr(2'd1);
    read_burst(16'h00A5, 3, 1'b1, "rd3");

    // 4: read request raised at ctr==2 waits for the next ctr==1.
    wait_ctr(2'd2);
    req = 1'b1; wr = 1'b0; addr = 16'h0010;
    check_idle("hold_c2");
    adv(); check_idle("hold_c3");
    adv(); check_idle("hold_c0");
    adv(); check_idle("hold_c1");
    mem_w[0] = 16'h9876;
    read_burst(16'h0010, 1, 1'b0, "rd4");

    // 5: reset during address nibble 3, then a fresh burst.
    wait_ctr(2'd3);
    req = 1'b1; wr = 1'b1; addr = 16'h00FF; wdata = 16'h1111;
    push_header(CMD_WRITE, 16'h00FF);
    for (int i = 0; i < 6; i++) begin
      adv();
      req = 1'b0;
      if (i == 5) rst = 1'b1;
      check_cycle("rstmid");
    end
    adv();
    rst = 1'b0;
    check_idle("rstmid");
    pin_q.delete();
    wait_ctr(2'd3);
    write_burst(16'h0F0F, 16'h5A3C, "wr5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=%0d expected=0", 1);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
